// File: rtl/modexp_pkg.sv
// Shared types and helpers for the right-to-left modular exponentiation engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package modexp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        ITER   = 2'd2,
        FIN    = 2'd3
    } state_t;

    // Cycles a serial multiply needs after it is issued.
    function automatic int mul_latency(input int width);
        return width;
    endfunction

    // Cycles per exponent bit: one issue cycle plus the multiply.
    function automatic int iter_cycles(input int width);
        return width + 1;
    endfunction

    // 1 mod m is 0 only for m == 1 (the caller handles m == 0 separately).
    function automatic logic unit_residue(input logic mod_is_one);
        return ~mod_is_one;
    endfunction

endpackage

// File: rtl/modmul_serial.sv
// Interleaved MSB-first shift-add modular multiplier, y = a*b mod m (a, b < m).
// Latency: WIDTH cycles after go; rdy and y are valid together in the final step cycle.
// Backpressure: none; a go while running restarts the multiply.
module modmul_serial
    import modexp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] y,
    output logic             rdy
);

    localparam int LAT = mul_latency(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] p_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] p_nxt;

    // p < m and a < m keep both intermediate sums below 2m, so one subtract each suffices.
    always_comb begin
        m_ext = {1'b0, m_q};
        dbl   = {p_q, 1'b0};
        if (dbl >= m_ext) begin
            dbl = dbl - m_ext;
        end
        sum = dbl;
        if (b_q[WIDTH-1]) begin
            sum = dbl + {1'b0, a_q};
            if (sum >= m_ext) begin
                sum = sum - m_ext;
            end
        end
        p_nxt = sum[WIDTH-1:0];
    end

    assign rdy = active_q && (cnt_q == CNT_W'(LAT - 1));
    assign y   = p_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (go) begin
            a_q      <= a;
            b_q      <= b;
            m_q      <= m;
            p_q      <= '0;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            p_q   <= p_nxt;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q + 1'b1;
            if (rdy) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/modexp_rl_param.sv
// Right-to-left binary modular exponentiation r = base^exp mod modulus; MODEXP_EARLY_EXIT_EN stops on exhausted exponent.
// Latency: WIDTH*(WIDTH+2)+1 cycles (early exit: WIDTH + L*(WIDTH+1) + 1); zero modulus finishes after 1 cycle with err.
// Backpressure: none; start is ignored while busy and in the done cycle.
module modexp_rl_param
    import modexp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic [WIDTH-1:0] r,
    output logic             done,
    output logic             err
);

    localparam int ITER_LEN = iter_cycles(WIDTH);

    state_t           state_q, state_nxt;
    logic [WIDTH-1:0] base_q, base_nxt;
    logic [WIDTH-1:0] b_q, b_nxt;
    logic [WIDTH-1:0] acc_q, acc_nxt;
    logic [WIDTH-1:0] e_q, e_nxt;
    logic [WIDTH-1:0] m_q, m_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [CNT_W-1:0] iter_q, iter_nxt;
    logic             err_nxt;
    logic [WIDTH:0]   rem_ext;
    logic             mul_go;
    logic             last_iter;
    logic             skip_iter;

    logic [WIDTH-1:0] mul_y, sq_y;
    logic             mul_rdy, sq_rdy;

`ifdef MODEXP_EARLY_EXIT_EN
    assign last_iter = (iter_q == CNT_W'(WIDTH - 1)) || (e_q[WIDTH-1:1] == '0);
    assign skip_iter = (e_q == '0);
`else
    assign last_iter = (iter_q == CNT_W'(WIDTH - 1));
    assign skip_iter = 1'b0;
`endif

    modmul_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (mul_go),
        .a   (acc_q),
        .b   (b_q),
        .m   (m_q),
        .y   (mul_y),
        .rdy (mul_rdy)
    );

    modmul_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_sq (
        .clk (clk),
        .rst (rst),
        .go  (mul_go),
        .a   (b_q),
        .b   (b_q),
        .m   (m_q),
        .y   (sq_y),
        .rdy (sq_rdy)
    );

    always_comb begin
        state_nxt = state_q;
        base_nxt  = base_q;
        b_nxt     = b_q;
        acc_nxt   = acc_q;
        e_nxt     = e_q;
        m_nxt     = m_q;
        cnt_nxt   = cnt_q;
        iter_nxt  = iter_q;
        err_nxt   = err;
        rem_ext   = '0;
        mul_go    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_nxt     = modulus;
                    e_nxt     = exp;
                    base_nxt  = base;
                    b_nxt     = '0;
                    acc_nxt   = {{(WIDTH-1){1'b0}}, unit_residue(modulus == WIDTH'(1))};
                    cnt_nxt   = '0;
                    iter_nxt  = '0;
                    err_nxt   = (modulus == '0);
                    state_nxt = (modulus == '0) ? FIN : REDUCE;
                end
            end
            REDUCE: begin
                // b_q holds the running remainder while base shifts out MSB first.
                rem_ext = {b_q, base_q[WIDTH-1]};
                if (rem_ext >= {1'b0, m_q}) begin
                    rem_ext = rem_ext - {1'b0, m_q};
                end
                b_nxt    = rem_ext[WIDTH-1:0];
                base_nxt = base_q << 1;
                cnt_nxt  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = skip_iter ? FIN : ITER;
                end
            end
            ITER: begin
                mul_go  = (cnt_q == '0);
                cnt_nxt = cnt_q + 1'b1;
                if (mul_rdy && e_q[0]) begin
                    acc_nxt = mul_y;
                end
                if (sq_rdy) begin
                    b_nxt = sq_y;
                end
                if (cnt_q == CNT_W'(ITER_LEN - 1)) begin
                    cnt_nxt  = '0;
                    e_nxt    = e_q >> 1;
                    iter_nxt = iter_q + 1'b1;
                    if (last_iter) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            e_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            iter_q  <= '0;
            r       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            base_q  <= base_nxt;
            b_q     <= b_nxt;
            acc_q   <= acc_nxt;
            e_q     <= e_nxt;
            m_q     <= m_nxt;
            cnt_q   <= cnt_nxt;
            iter_q  <= iter_nxt;
            err     <= err_nxt;
            done    <= (state_nxt == FIN);
            busy    <= (state_nxt == REDUCE) || (state_nxt == ITER);
            // r is registered on FIN entry so it is valid in the done cycle.
            if (state_nxt == FIN) begin
                r <= err_nxt ? '0 : acc_nxt;
            end
        end
    end

endmodule
